// File: rtl/bsg_mesh_router_output_arb_wh.sv
// bsg_mesh_router_output_arb_wh
// Round-robin wormhole arbiter for a single mesh router output port.
module bsg_mesh_router_output_arb_wh #(
    parameter int num_in_p    = 5,
    parameter int width_p     = 32,
    parameter int len_width_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [num_in_p-1:0]             v_i,
    input  logic [num_in_p-1:0]             req_i,
    input  logic [num_in_p*len_width_p-1:0] len_i,
    input  logic [num_in_p*width_p-1:0]     data_i,
    output logic [num_in_p-1:0]             yumi_o,
    output logic                            v_o,
    output logic [width_p-1:0]              data_o,
    input  logic                            ready_i,
    output logic                            locked_o
);

    localparam int sel_width_lp =
        (num_in_p > 1) ? $clog2(num_in_p) : 1;

    localparam logic [sel_width_lp-1:0] last_lp =
        sel_width_lp'(num_in_p - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e state_r;
    state_e state_n;

    logic [sel_width_lp-1:0] sel_r;
    logic [sel_width_lp-1:0] sel_n;
    logic [sel_width_lp-1:0] ptr_r;
    logic [sel_width_lp-1:0] ptr_n;
    logic [sel_width_lp-1:0] win;
    logic [sel_width_lp-1:0] mux_sel;
    logic [len_width_p-1:0]  cnt_r;
    logic [len_width_p-1:0]  cnt_n;
    logic [num_in_p-1:0]     cand;
    logic                    found;
    logic                    xfer;

    logic [width_p-1:0]     data_a [num_in_p];
    logic [len_width_p-1:0] len_a  [num_in_p];

    for (genvar g = 0; g < num_in_p; g++) begin : g_unpack
        assign data_a[g] = data_i[g*width_p +: width_p];
        assign len_a[g]  = len_i[g*len_width_p +: len_width_p];
    end

    assign cand = v_i & req_i;

    // Scan candidates upward from the priority pointer, wrapping around.
    always_comb begin
        int idx;
        logic [sel_width_lp-1:0] idx_v;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_v = '0;
        for (int k = 0; k < num_in_p; k++) begin
            idx = int'(ptr_r) + k;
            if (idx >= num_in_p) begin
                idx = idx - num_in_p;
            end
            idx_v = sel_width_lp'(idx);
            if (!found && cand[idx_v]) begin
                found = 1'b1;
                win   = idx_v;
            end
        end
    end

    // Output mux: locked input while mid-packet, else the header winner.
    always_comb begin
        mux_sel  = win;
        v_o      = found;
        locked_o = 1'b0;
        if (state_r == LOCKED) begin
            mux_sel  = sel_r;
            v_o      = v_i[sel_r];
            locked_o = 1'b1;
        end
        data_o = data_a[mux_sel];
        xfer   = v_o & ready_i;
        yumi_o = '0;
        if (xfer) begin
            yumi_o[mux_sel] = 1'b1;
        end
    end

    // Next-state: header grants lock, body transfers count down to zero.
    always_comb begin
        state_n = state_r;
        sel_n   = sel_r;
        cnt_n   = cnt_r;
        ptr_n   = ptr_r;
        unique case (state_r)
            IDLE: begin
                if (xfer) begin
                    ptr_n = (win == last_lp) ? '0 : win + 1'b1;
                    if (len_a[win] != '0) begin
                        sel_n   = win;
                        cnt_n   = len_a[win];
                        state_n = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    cnt_n = cnt_r - 1'b1;
                    if (cnt_r == len_width_p'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            sel_r   <= '0;
            cnt_r   <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_n;
            sel_r   <= sel_n;
            cnt_r   <= cnt_n;
            ptr_r   <= ptr_n;
        end
    end

endmodule

// File: tb/tb_bsg_mesh_router_output_arb_wh.sv
// tb_bsg_mesh_router_output_arb_wh
// Directed and random stimulus against a packet-level reference model.
module tb_bsg_mesh_router_output_arb_wh;

    localparam int N  = 5;
    localparam int W  = 32;
    localparam int LW = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    v;
    logic [N-1:0]    req;
    logic [N*LW-1:0] len;
    logic [N*W-1:0]  data;
    logic [N-1:0]    yumi;
    logic            v_o;
    logic [W-1:0]    data_o;
    logic            ready;
    logic            locked;

    int checks;
    int failures;

    int m_locked;
    int m_sel;
    int m_rem;
    int m_ptr;
    int seq [N];

    logic [N-1:0] last_yumi;

    bsg_mesh_router_output_arb_wh #(
        .num_in_p   (N),
        .width_p    (W),
        .len_width_p(LW)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .v_i      (v),
        .req_i    (req),
        .len_i    (len),
        .data_i   (data),
        .yumi_o   (yumi),
        .v_o      (v_o),
        .data_o   (data_o),
        .ready_i  (ready),
        .locked_o (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int len_of(input int i);
        logic [N*LW-1:0] l;
        l = len;
        return int'(l[i*LW +: LW]);
    endfunction

    task automatic refresh_data();
        for (int i = 0; i < N; i++) begin
            data[i*W +: W] = {8'(i), 24'(seq[i])};
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_sel    = 0;
        m_rem    = 0;
        m_ptr    = 0;
    endtask

    // One clock: compare outputs against the model, then advance it.
    task automatic do_cycle();
        int w;
        int ev;
        logic [N-1:0] ey;
        logic [W-1:0] ed;
        refresh_data();
        #3;
        w  = -1;
        ev = 0;
        ey = '0;
        ed = '0;
        if (m_locked != 0) begin
            w  = m_sel;
            ev = int'(v[m_sel]);
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (w < 0 && v[i] && req[i]) w = i;
            end
            ev = (w >= 0) ? 1 : 0;
        end
        if (ev != 0) begin
            ed = data[w*W +: W];
            if (ready) ey[w] = 1'b1;
        end
        chk("v_o", 64'(v_o), 64'(ev));
        chk("yumi", 64'(yumi), 64'(ey));
        chk("locked", 64'(locked), 64'(m_locked));
        if (ev != 0) chk("data_o", 64'(data_o), 64'(ed));
        last_yumi = yumi;
        @(posedge clk);
        if (ev != 0 && ready) begin
            seq[w] = seq[w] + 1;
            if (m_locked != 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_locked = 0;
            end else begin
                m_ptr = (w + 1) % N;
                if (len_of(w) != 0) begin
                    m_locked = 1;
                    m_sel    = w;
                    m_rem    = len_of(w);
                end
            end
        end
        #1;
    endtask

    task automatic set_len(input int i, input int l);
        len[i*LW +: LW] = LW'(l);
    endtask

    initial begin
        int grants [6];
        int budget;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        model_reset();
        rst_n = 1'b0;
        v     = '0;
        req   = '0;
        len   = '0;
        ready = 1'b0;
        refresh_data();

        #2;
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_yumi", 64'(yumi), 64'd0);
        chk("rst_v_o", 64'(v_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-flit fairness among inputs 0, 2, 4.
        grants = '{0, 2, 4, 0, 2, 4};
        v     = 5'b10101;
        req   = 5'b10101;
        len   = '0;
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            do_cycle();
            chk("fair_grant", 64'(last_yumi), 64'(1 << grants[k]));
        end

        // Wormhole lock: input 1 sends 4 flits, input 3 waits.
        v   = 5'b01010;
        req = 5'b01010;
        len = '0;
        set_len(1, 3);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) set_len(1, 0);
            if (k == 4) begin
                v   = 5'b01000;
                req = 5'b01000;
            end
            do_cycle();
            chk("worm_grant", 64'(last_yumi),
                (k < 4) ? 64'h02 : 64'h08);
        end

        // Backpressure and 2-cycle bubbles inside a packet.
        v   = 5'b01000;
        req = 5'b01000;
        len = '0;
        set_len(3, 10);
        ready = 1'b1;
        do_cycle();
        budget = 0;
        while (m_locked != 0 && budget < 200) begin
            v     = ((budget % 4) < 2) ? 5'b01000 : 5'b00000;
            req   = 5'($urandom);
            ready = 1'($urandom);
            len   = 20'($urandom);
            do_cycle();
            budget++;
        end
        chk("bubble_done", 64'(m_locked), 64'd0);

        // No transfer: priority must not move.
        v     = 5'b00011;
        req   = 5'b00011;
        len   = '0;
        ready = 1'b0;
        for (int k = 0; k < 10; k++) do_cycle();
        ready = 1'b1;
        do_cycle();
        chk("hold_grant", 64'(last_yumi), 64'h01);

        // Maximum length with a requesting but invalid input.
        v   = 5'b00100;
        req = 5'b10100;
        len = '0;
        set_len(2, 15);
        set_len(4, 0);
        for (int k = 0; k < 16; k++) begin
            do_cycle();
            chk("max_grant", 64'(last_yumi), 64'h04);
        end
        v = 5'b00000;
        do_cycle();
        chk("max_idle", 64'(locked), 64'd0);

        // Asynchronous reset after 2 of 5 flits.
        v   = 5'b00001;
        req = 5'b00001;
        len = '0;
        set_len(0, 4);
        do_cycle();
        set_len(0, 0);
        do_cycle();
        chk("pre_rst_locked", 64'(locked), 64'd1);
        #2;
        rst_n = 1'b0;
        v     = '0;
        req   = '0;
        #1;
        chk("arst_locked", 64'(locked), 64'd0);
        chk("arst_yumi", 64'(yumi), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v     = 5'b00101;
        req   = 5'b00101;
        len   = '0;
        ready = 1'b1;
        do_cycle();
        chk("post_rst_grant", 64'(last_yumi), 64'h01);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            v     = 5'($urandom);
            req   = 5'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                set_len(i, ($urandom_range(0, 3) == 0) ?
                           int'($urandom_range(1, 15)) : 0);
            end
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_mesh_router_output_arb_wh.md
# bsg_mesh_router_output_arb_wh

Per-output-port wormhole arbiter for the mesh router. One instance sits downstream of the dimension-ordered route decoders, one per output direction. Each input port's decoder drives one request bit into it. The block picks one requesting input round-robin on its header flit, then locks the output to that input until the packet's body flits have passed. It drives a valid/ready link toward the output channel and returns yumi (consume) strobes to the input FIFOs.

## Interface
- `num_in_p`, default 5: number of input ports competing for this output (P, W, E, N, S order for a 2-D mesh); must be ≥ 1.
- `width_p`, default 32: flit width in bits.
- `len_width_p`, default 4: width of the packet-length field; the field carries the number of body flits following the header.
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `reset_n_i`, input, 1: asynchronous, active-low reset.
- `v_i`, input, num_in_p: per-input flit valid (input FIFO not empty).
- `req_i`, input, num_in_p: decoder request bit for this output; meaningful only on header flits.
- `len_i`, input, num_in_p*len_width_p: per-input body-flit count taken from the header flit; input i occupies bits [i*len_width_p +: len_width_p].
- `data_i`, input, num_in_p*width_p: per-input flit data.
- `yumi_o`, output, num_in_p: one-hot or zero; flit at input i is consumed this cycle.
- `v_o`, output, 1: output flit valid.
- `data_o`, output, width_p: output flit.
- `ready_i`, input, 1: downstream accepts a flit this cycle.
- `locked_o`, output, 1: arbiter is mid-packet (status/debug).

## Operation
- State: `state_r` ∈ {IDLE, LOCKED}; `sel_r` (log2 num_in_p bits) is the locked input; `cnt_r` (len_width_p bits) holds remaining body flits; `ptr_r` is the round-robin priority pointer.
- IDLE:
  - Candidate set is `c = v_i & req_i`.
  - Winner `w` is the first set bit of `c` scanning upward from `ptr_r`, wrapping modulo num_in_p.
  - `v_o = |c` and `data_o = data_i[w]`.
  - A transfer occurs when `v_o & ready_i`. On a transfer: `yumi_o[w] = 1` and `ptr_r <= (w+1) mod num_in_p`.
  - If `len_i[w] == 0`, stay in IDLE (single-flit packet). Otherwise `sel_r <= w`, `cnt_r <= len_i[w]`, and the state moves to LOCKED.
- LOCKED:
  - `v_o = v_i[sel_r]` and `data_o = data_i[sel_r]`.
  - `req_i` is ignored for all inputs.
  - `yumi_o[sel_r] = v_i[sel_r] & ready_i`; all other yumi bits are 0.
  - Each transfer decrements `cnt_r`. A transfer with `cnt_r == 1` returns the state to IDLE.
  - A bubble (`v_i[sel_r] = 0`) holds the lock with no change to state.
- `locked_o = (state_r == LOCKED)`.
- Inputs with `v_i = 0` never win, regardless of `req_i`. With no candidates, `v_o = 0` and `yumi_o = 0`.
- `ptr_r` changes only on a header transfer, so an unaccepted offer does not rotate priority.
- While `ready_i = 0` in IDLE, the winner may change if a higher-priority candidate appears. This is legal because nothing transferred.
- Reset asserted mid-packet forces IDLE and abandons the lock. Recovering the upstream/downstream packet state is the system's responsibility.

## Timing
- Reset values: `state_r` = IDLE, `ptr_r` = 0, `sel_r` = 0, `cnt_r` = 0.
  - Output values while reset is asserted: `locked_o` = 0, `yumi_o` = 0 and `v_o` = 0 (given `v_i` = 0).
- Zero-cycle latency: `v_o`, `data_o`, and `yumi_o` are combinational from the inputs and registered state. A flit can pass through in the cycle it arrives.
- `v_o` and `data_o` never depend on `ready_i`. `yumi_o` depends on `ready_i`, and `yumi_o[i]` implies `v_i[i]`.
- A packet of `L` body flits holds the output for exactly `L+1` transfers.
- Back-to-back packets: a new header may transfer in the cycle after the tail transfer. There is no idle cycle requirement.
- `cnt_r` is compared against 1 before decrementing, so it never wraps. A length of `2^len_width_p − 1` is legal.

## Test plan
- Single-flit fairness: num_in_p = 5; inputs 0, 2, 4 hold `req_i` and `v_i` with `len_i = 0`; `ready_i = 1` → grants 0, 2, 4, 0, 2, … one per cycle, and `ptr_r` follows 1, 3, 0, 1.
- Wormhole lock: input 1 sends a header with `len_i = 3` while input 3 also requests → output carries input 1 for 4 consecutive transfers; `yumi_o[3] = 0` throughout; input 3 wins on the 5th cycle.
- Backpressure and bubbles during a packet: `ready_i` toggles and `v_i[sel]` has 2-cycle gaps → `locked_o` stays 1; `cnt_r` decrements only on `v_o & ready_i`; no flit is lost or duplicated (scoreboard on `data_o`).
- No-transfer priority hold: `ready_i = 0` for 10 cycles with inputs 0 and 1 requesting → `ptr_r` stays unchanged and `yumi_o = 0`.
- Boundary length: `len_i = 15` (`len_width_p = 4`) → exactly 16 transfers, then IDLE; input with `req_i = 1` but `v_i = 0` is never granted.
- Asynchronous reset mid-packet: assert `reset_n_i` between clock edges after 2 of 5 flits → `locked_o` and `yumi_o` go 0 immediately; after release, the arbiter is in IDLE with `ptr_r = 0`.
